fp_addsub_scheduler: RTL and testbench

Shares one combinational `fp_adder_subber` instance between two requesters (port 0 and port 1) using round-robin arbitration. It registers the granted operands, drives them into the adder for one evaluation cycle, and captures the result and exception flags. It then returns the result with a requester ID over a valid/ready response channel. It also keeps sticky exception flags for software status reads.

---
 rtl/fp_addsub_scheduler.sv | 161 ++++++++++++++++
 tb/tb_fp_addsub_scheduler.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_addsub_scheduler.sv
// rtl/fp_addsub_scheduler.sv - round-robin scheduler sharing one combinational fp adder between two requesters
//
// Purpose: arbitrates two operation request ports onto a single external
// combinational fp_adder_subber. The granted operands are registered and held
// on the add_* outputs. The adder result is captured after one evaluation
// cycle and returned with the requester ID over a valid/ready response channel.
// Exception flags are also accumulated into sticky status bits.
//
// Ports:
//   clk, rst                      clock, asynchronous active-low reset
//   reqN_valid / reqN_ready       request handshake for port N (N = 0, 1)
//   reqN_mode_fp, reqN_op         0 = half / 1 = single precision; 0 = add / 1 = sub
//   reqN_a, reqN_b                packed operands {sign, exp[7:0], mant[22:0]}
//   round_mode                    passed straight through to add_round_mode
//   add_*  (out)                  adder operand inputs, driven from operand registers
//   add_result_*, add_overflow,
//   add_underflow, add_inexact    adder result and exception outputs
//   rsp_valid / rsp_ready         response handshake
//   rsp_id, rsp_result, rsp_flags requester ID, packed result, {ovf, unf, inx}
//   sticky_flags, flag_clr        accumulated {ovf, unf, inx}; synchronous clear
//   busy                          high whenever the scheduler is not idle

module fp_addsub_scheduler #(
  parameter bit RR_INIT = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic        req0_mode_fp,
  input  logic        req0_op,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic        req1_mode_fp,
  input  logic        req1_op,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  input  logic        round_mode,
  output logic        add_mode_fp,
  output logic        add_operation,
  output logic        add_sign_a,
  output logic        add_sign_b,
  output logic [7:0]  add_exp_a,
  output logic [7:0]  add_exp_b,
  output logic [22:0] add_mant_a,
  output logic [22:0] add_mant_b,
  output logic        add_round_mode,
  input  logic        add_result_sign,
  input  logic [7:0]  add_result_exp,
  input  logic [22:0] add_result_mant,
  input  logic        add_overflow,
  input  logic        add_underflow,
  input  logic        add_inexact,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [31:0] rsp_result,
  output logic [2:0]  rsp_flags,
  output logic [2:0]  sticky_flags,
  input  logic        flag_clr,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        last_grant_q;
  logic        id_q;
  logic        op_mode_q;
  logic        op_sub_q;
  logic [31:0] op_a_q;
  logic [31:0] op_b_q;
  logic        grant;
  logic        handshake;
  logic        capture;
  logic [2:0]  cap_flags;

  // With both ports valid the port that did not win last time is served;
  // otherwise whichever port is valid wins (port 1 iff only port 1 is valid).
  assign grant     = (req0_valid && req1_valid) ? ~last_grant_q : req1_valid;
  // rst gating keeps both readies low while reset is held, even though the
  // state register already reads IDLE.
  assign handshake = rst && (state_q == IDLE) && (req0_valid || req1_valid);
  assign req0_ready = handshake && !grant;
  assign req1_ready = handshake && grant;

  assign capture   = (state_q == EXEC);
  assign cap_flags = {add_overflow, add_underflow, add_inexact};

  assign rsp_valid = (state_q == RESP);
  assign rsp_id    = id_q;
  assign busy      = (state_q != IDLE);

  // Operand registers only change on a handshake, so the adder inputs stay
  // constant for the whole operation.
  assign add_mode_fp    = op_mode_q;
  assign add_operation  = op_sub_q;
  assign add_sign_a     = op_a_q[31];
  assign add_exp_a      = op_a_q[30:23];
  assign add_mant_a     = op_a_q[22:0];
  assign add_sign_b     = op_b_q[31];
  assign add_exp_b      = op_b_q[30:23];
  assign add_mant_b     = op_b_q[22:0];
  assign add_round_mode = round_mode;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (handshake) state_d = EXEC;
      EXEC:    state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      last_grant_q <= RR_INIT;
      id_q         <= 1'b0;
      op_mode_q    <= 1'b0;
      op_sub_q     <= 1'b0;
      op_a_q       <= '0;
      op_b_q       <= '0;
    end else begin
      state_q <= state_d;
      if (handshake) begin
        last_grant_q <= grant;
        id_q         <= grant;
        op_mode_q    <= grant ? req1_mode_fp : req0_mode_fp;
        op_sub_q     <= grant ? req1_op      : req0_op;
        op_a_q       <= grant ? req1_a       : req0_a;
        op_b_q       <= grant ? req1_b       : req0_b;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rsp_result   <= '0;
      rsp_flags    <= '0;
      sticky_flags <= '0;
    end else begin
      if (capture) begin
        rsp_result <= {add_result_sign, add_result_exp, add_result_mant};
        rsp_flags  <= cap_flags;
        // A clear landing on the capture edge keeps only the new flags.
        sticky_flags <= flag_clr ? cap_flags : (sticky_flags | cap_flags);
      end else if (flag_clr) begin
        sticky_flags <= '0;
      end
    end
  end

endmodule

// File: tb/tb_fp_addsub_scheduler.sv
// tb/tb_fp_addsub_scheduler.sv - randomized self-checking bench for fp_addsub_scheduler

module tb_fp_addsub_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req0_ready, req0_mode_fp, req0_op;
  logic [31:0] req0_a, req0_b;
  logic        req1_valid, req1_ready, req1_mode_fp, req1_op;
  logic [31:0] req1_a, req1_b;
  logic        round_mode;
  logic        add_mode_fp, add_operation, add_sign_a, add_sign_b;
  logic [7:0]  add_exp_a, add_exp_b;
  logic [22:0] add_mant_a, add_mant_b;
  logic        add_round_mode;
  logic        add_result_sign;
  logic [7:0]  add_result_exp;
  logic [22:0] add_result_mant;
  logic        add_overflow, add_underflow, add_inexact;
  logic        rsp_valid, rsp_ready, rsp_id;
  logic [31:0] rsp_result;
  logic [2:0]  rsp_flags, sticky_flags;
  logic        flag_clr, busy;

  always #5 clk = ~clk;

  fp_addsub_scheduler #(.RR_INIT(1'b1)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_mode_fp(req0_mode_fp),
    .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_mode_fp(req1_mode_fp),
    .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
    .round_mode(round_mode),
    .add_mode_fp(add_mode_fp), .add_operation(add_operation),
    .add_sign_a(add_sign_a), .add_sign_b(add_sign_b),
    .add_exp_a(add_exp_a), .add_exp_b(add_exp_b),
    .add_mant_a(add_mant_a), .add_mant_b(add_mant_b),
    .add_round_mode(add_round_mode),
    .add_result_sign(add_result_sign), .add_result_exp(add_result_exp),
    .add_result_mant(add_result_mant),
    .add_overflow(add_overflow), .add_underflow(add_underflow), .add_inexact(add_inexact),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_flags(rsp_flags),
    .sticky_flags(sticky_flags), .flag_clr(flag_clr), .busy(busy)
  );

  // Behavioural fp add/sub: returns {ovf, unf, inx, sign, exp, mant}.
  // Half mode uses the single-precision field layout with a half range
  // (exp 113..142) and an 11-bit significand. rm: 0 = nearest-even, 1 = truncate.
  function automatic logic [34:0] fp_model(input logic mode, input logic op, input logic rm,
                                           input logic [31:0] a, input logic [31:0] b);
    logic        sa, sb, sr, ts, inexact, jam;
    int          ea, eb, e, te, d, p, lowpos, emax, emin;
    logic [55:0] x, y, s, t, keep, rem, half;
    logic [22:0] mant;
    sa = a[31];
    sb = b[31] ^ op;
    ea = {24'd0, a[30:23]};
    eb = {24'd0, b[30:23]};
    x = (ea == 0) ? 56'd0 : {2'b00, 1'b1, a[22:0], 30'd0};
    y = (eb == 0) ? 56'd0 : {2'b00, 1'b1, b[22:0], 30'd0};
    if (ea < eb || (ea == eb && x < y)) begin
      t = x; x = y; y = t;
      te = ea; ea = eb; eb = te;
      ts = sa; sa = sb; sb = ts;
    end
    d = ea - eb;
    if (d > 55) begin
      jam = |y;
      y = 56'd0;
    end else begin
      jam = |(y & ((56'd1 << d) - 56'd1));
      y = y >> d;
    end
    y[0] = y[0] | jam;
    s = (sa == sb) ? x + y : x - y;
    if (s == 56'd0) return 35'd0;
    e = ea;
    sr = sa;
    if (s[54]) begin
      s = (s >> 1) | (s & 56'd1);
      e = e + 1;
    end
    for (int i = 0; i < 55; i++) begin
      if (!s[53]) begin
        s = s << 1;
        e = e - 1;
      end
    end
    p = mode ? 24 : 11;
    lowpos = 54 - p;
    keep = s >> lowpos;
    rem  = s & ((56'd1 << lowpos) - 56'd1);
    half = 56'd1 << (lowpos - 1);
    inexact = (rem != 56'd0);
    if (!rm && (rem > half || (rem == half && keep[0]))) keep = keep + 56'd1;
    if (keep[p]) begin
      keep = keep >> 1;
      e = e + 1;
    end
    emax = mode ? 254 : 142;
    emin = mode ? 1 : 113;
    if (e > emax) return {3'b101, sr, 8'(emax + 1), 23'd0};
    if (e < emin) return {3'b011, sr, 31'd0};
    mant = 23'((keep & ((56'd1 << (p - 1)) - 56'd1)) << (24 - p));
    return {2'b00, inexact, sr, 8'(e), mant};
  endfunction

  // Adder environment driven by the DUT's operand outputs.
  always_comb begin
    {add_overflow, add_underflow, add_inexact, add_result_sign, add_result_exp, add_result_mant} =
      fp_model(add_mode_fp, add_operation, add_round_mode,
               {add_sign_a, add_exp_a, add_mant_a}, {add_sign_b, add_exp_b, add_mant_b});
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference state: stage 0 = free, 1 = operation evaluating, 2 = response pending.
  int          m_stage;
  logic        m_last, m_id, m_acc0, m_acc1;
  logic [31:0] m_res;
  logic [2:0]  m_flags, m_sticky;
  int          cyc = 0;

  task automatic model_reset();
    m_stage = 0; m_last = 1'b1; m_sticky = 3'b000; m_acc0 = 1'b0; m_acc1 = 1'b0;
  endtask

  task automatic step(input string tag);
    logic        hs, g, cap;
    logic [34:0] r;
    #1;
    hs = (m_stage == 0) && (req0_valid || req1_valid);
    g  = (req0_valid && req1_valid) ? ~m_last : req1_valid;
    check({tag, ".rdy0"}, req0_ready, hs && !g);
    check({tag, ".rdy1"}, req1_ready, hs && g);
    m_acc0 = hs && !g;
    m_acc1 = hs && g;
    if (hs) begin
      if (g) r = fp_model(req1_mode_fp, req1_op, round_mode, req1_a, req1_b);
      else   r = fp_model(req0_mode_fp, req0_op, round_mode, req0_a, req0_b);
      m_res = r[31:0];
      m_flags = r[34:32];
    end
    cap = (m_stage == 1);
    @(posedge clk);
    #1;
    cyc++;
    if (cap) m_sticky = flag_clr ? m_flags : (m_sticky | m_flags);
    else if (flag_clr) m_sticky = 3'b000;
    case (m_stage)
      0: if (hs) begin m_stage = 1; m_last = g; m_id = g; end
      1: m_stage = 2;
      default: if (rsp_ready) m_stage = 0;
    endcase
    check({tag, ".valid"}, rsp_valid, m_stage == 2);
    check({tag, ".busy"}, busy, m_stage != 0);
    check({tag, ".sticky"}, sticky_flags, m_sticky);
    if (m_stage == 2) begin
      check({tag, ".id"}, rsp_id, m_id);
      check({tag, ".result"}, rsp_result, m_res);
      check({tag, ".flags"}, rsp_flags, m_flags);
    end
  endtask

  function automatic logic [31:0] rnd_operand(input logic mode);
    logic [31:0] r;
    r = $urandom;
    if ($urandom_range(0, 15) == 0) r[30:23] = 8'd0;
    else if (mode) r[30:23] = 8'($urandom_range(1, 254));
    else r[30:23] = 8'($urandom_range(113, 142));
    if (!mode) r[12:0] = 13'd0;
    return r;
  endfunction

  task automatic set_req(input logic p, input logic mode, input logic op,
                         input logic [31:0] a, input logic [31:0] b);
    if (p) begin
      req1_valid = 1'b1; req1_mode_fp = mode; req1_op = op; req1_a = a; req1_b = b;
    end else begin
      req0_valid = 1'b1; req0_mode_fp = mode; req0_op = op; req0_a = a; req0_b = b;
    end
  endtask

  task automatic new_req(input logic p);
    logic mode;
    mode = 1'($urandom);
    set_req(p, mode, 1'($urandom), rnd_operand(mode), rnd_operand(mode));
  endtask

  task automatic drain();
    rsp_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (m_stage == 0 && !req0_valid && !req1_valid) break;
      step("drain");
      if (m_acc0) req0_valid = 1'b0;
      if (m_acc1) req1_valid = 1'b0;
    end
    check("drain_idle", busy, 1'b0);
  endtask

  task automatic run_op(input logic p, input logic mode, input logic op,
                        input logic [31:0] a, input logic [31:0] b, input logic clr,
                        output logic [31:0] res, output logic [2:0] fl);
    rsp_ready = 1'b1;
    set_req(p, mode, op, a, b);
    step("op_hs");
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    flag_clr = clr;
    step("op_cap");
    flag_clr = 1'b0;
    res = rsp_result;
    fl = rsp_flags;
    step("op_done");
  endtask

  int          rsp_ids[$];
  int          rsp_cyc[$];
  int          issued;
  logic [31:0] res;
  logic [2:0]  fl;

  initial begin
    rst = 1'b0;
    req0_valid = 1'b1; req0_mode_fp = 1'b1; req0_op = 1'b0; req0_a = 32'h3F800000; req0_b = 32'h3F800000;
    req1_valid = 1'b1; req1_mode_fp = 1'b1; req1_op = 1'b0; req1_a = 32'h3F800000; req1_b = 32'h3F800000;
    round_mode = 1'b0; rsp_ready = 1'b1; flag_clr = 1'b0;
    model_reset();
    #2;
    check("rst_rdy0", req0_ready, 1'b0);
    check("rst_rdy1", req1_ready, 1'b0);
    check("rst_valid", rsp_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_result", rsp_result, 32'h0);
    check("rst_flags", rsp_flags, 3'b000);
    check("rst_sticky", sticky_flags, 3'b000);
    check("rst_id", rsp_id, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;

    // Contention: both ports valid for four operations.
    new_req(1'b0);
    new_req(1'b1);
    issued = 2;
    for (int i = 0; i < 20 && rsp_ids.size() < 4; i++) begin
      step("cont");
      if (rsp_valid) begin
        rsp_ids.push_back(int'(rsp_id));
        rsp_cyc.push_back(cyc);
      end
      if (m_acc0) begin if (issued < 4) begin new_req(1'b0); issued++; end else req0_valid = 1'b0; end
      if (m_acc1) begin if (issued < 4) begin new_req(1'b1); issued++; end else req1_valid = 1'b0; end
    end
    check("cont_count", rsp_ids.size(), 4);
    if (rsp_ids.size() == 4) begin
      for (int i = 0; i < 4; i++) check("cont_order", rsp_ids[i], i % 2);
      for (int i = 0; i < 3; i++) check("cont_spacing", rsp_cyc[i + 1] - rsp_cyc[i], 3);
    end
    drain();

    // Single request with latency check.
    set_req(1'b0, 1'b1, 1'b0, 32'h3F800000, 32'h40000000);
    step("single_hs");
    req0_valid = 1'b0;
    check("single_lat1", rsp_valid, 1'b0);
    step("single_exec");
    check("single_valid", rsp_valid, 1'b1);
    check("single_id", rsp_id, 1'b0);
    check("single_result", rsp_result, 32'h40400000);
    check("single_flags", rsp_flags, 3'b000);
    step("single_done");

    // Backpressure: response held while a competing request waits.
    rsp_ready = 1'b0;
    new_req(1'b0);
    step("bp_hs");
    req0_valid = 1'b0;
    step("bp_exec");
    new_req(1'b1);
    repeat (5) step("bp_hold");
    check("bp_rdy1", req1_ready, 1'b0);
    rsp_ready = 1'b1;
    step("bp_release");
    check("bp_idle", busy, 1'b0);
    drain();

    // Sticky flags.
    flag_clr = 1'b1;
    step("stk_clr0");
    flag_clr = 1'b0;
    run_op(1'b0, 1'b1, 1'b0, 32'h7F000000, 32'h7F000000, 1'b0, res, fl);
    check("stk_ovf_result", res, 32'h7F800000);
    check("stk_ovf_flag", fl[2], 1'b1);
    check("stk_ovf_set", sticky_flags[2], 1'b1);
    run_op(1'b1, 1'b1, 1'b0, 32'h3F800000, 32'h40000000, 1'b0, res, fl);
    check("stk_persist", sticky_flags[2], 1'b1);
    flag_clr = 1'b1;
    step("stk_clr");
    flag_clr = 1'b0;
    check("stk_cleared", sticky_flags, 3'b000);
    run_op(1'b0, 1'b1, 1'b0, 32'h3F800000, 32'h30800000, 1'b1, res, fl);
    check("stk_set_wins", sticky_flags, 3'b001);

    // Half-precision overflow.
    run_op(1'b1, 1'b0, 1'b0, {1'b0, 8'd142, 23'h7FE000}, {1'b0, 8'd142, 23'h7FE000}, 1'b0, res, fl);
    check("half_ovf_flag", fl[2], 1'b1);
    check("half_ovf_exp", res[30:23], 8'd143);
    check("half_ovf_mant", res[22:0], 23'd0);

    // Reset during EXEC.
    new_req(1'b0);
    step("mid_hs");
    req0_valid = 1'b0;
    new_req(1'b1);
    #2;
    rst = 1'b0;
    #1;
    check("mid_valid", rsp_valid, 1'b0);
    check("mid_busy", busy, 1'b0);
    check("mid_rdy0", req0_ready, 1'b0);
    check("mid_rdy1", req1_ready, 1'b0);
    check("mid_result", rsp_result, 32'h0);
    check("mid_flags", rsp_flags, 3'b000);
    check("mid_sticky", sticky_flags, 3'b000);
    check("mid_id", rsp_id, 1'b0);
    check("mid_exp_a", add_exp_a, 8'd0);
    check("mid_mant_b", add_mant_b, 23'd0);
    @(posedge clk);
    #1;
    check("mid_hold_busy", busy, 1'b0);
    check("mid_hold_valid", rsp_valid, 1'b0);
    rst = 1'b1;
    model_reset();
    drain();

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      rsp_ready = ($urandom_range(0, 3) != 0);
      flag_clr = ($urandom_range(0, 7) == 0);
      if (m_stage == 0) round_mode = 1'($urandom);
      if (!req0_valid && $urandom_range(0, 2) == 0) new_req(1'b0);
      if (!req1_valid && $urandom_range(0, 2) == 0) new_req(1'b1);
      step("rand");
      if (m_acc0) req0_valid = 1'b0;
      if (m_acc1) req1_valid = 1'b0;
    end
    flag_clr = 1'b0;
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
